range_finder_v2: RTL

- Parametrised successor to the single-mode 8-bit range finder.
- Tracks min/max of a sample stream framed by go/finish pulses and reports one of four statistics: range, min, max or midpoint.
- Also reports a saturating sample count and separate valid/busy/error status.
- Sits directly behind the tile I/O wrapper; ui_in feeds data_in, uo_out carries result.

---
 rtl/range_finder_v2_pkg.sv | 18 +
 rtl/range_minmax_unit.sv | 64 ++++++
 rtl/range_finder_v2.sv | 121 ++++++++++++
 3 files changed

// File: rtl/range_finder_v2_pkg.sv
// Shared types for range_finder_v2: FSM state and statistic-select encodings.
// Optional feature macro: RANGE_FINDER_V2_SIGNED_EN (see range_minmax_unit / range_finder_v2).
package range_finder_v2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      MODE_RANGE = 2'd0,
      MODE_MIN   = 2'd1,
      MODE_MAX   = 2'd2,
      MODE_MID   = 2'd3
   } mode_t;

endpackage

// File: rtl/range_minmax_unit.sv
// Running min/max tracker; range and midpoint are derived from the post-update values.
// RANGE_FINDER_V2_SIGNED_EN selects two's-complement compares and a saturating range.
module range_minmax_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             upd_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] min_o,
   output logic [WIDTH-1:0] max_o,
   output logic [WIDTH-1:0] range_o,
   output logic [WIDTH-1:0] mid_o
);

   logic [WIDTH-1:0] min_q, min_d;
   logic [WIDTH-1:0] max_q, max_d;
   logic             lt_min, gt_max;
   logic [WIDTH:0]   sum;

`ifdef RANGE_FINDER_V2_SIGNED_EN
   logic [WIDTH:0]   diff;

   assign lt_min  = $signed(data_i) < $signed(min_q);
   assign gt_max  = $signed(data_i) > $signed(max_q);
   assign diff    = {max_d[WIDTH-1], max_d} - {min_d[WIDTH-1], min_d};
   assign range_o = diff[WIDTH] ? '1 : diff[WIDTH-1:0];
   assign sum     = {max_d[WIDTH-1], max_d} + {min_d[WIDTH-1], min_d};
`else
   assign lt_min  = data_i < min_q;
   assign gt_max  = data_i > max_q;
   assign range_o = max_d - min_d;
   assign sum     = {1'b0, max_d} + {1'b0, min_d};
`endif

   // Taking bits [WIDTH:1] is the shift; the sign-extended sum makes it arithmetic.
   assign mid_o = sum[WIDTH:1];
   assign min_o = min_d;
   assign max_o = max_d;

   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (load_i) begin
         min_d = data_i;
         max_d = data_i;
      end else if (upd_i) begin
         if (lt_min) min_d = data_i;
         if (gt_max) max_d = data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_q <= '0;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

endmodule

// File: rtl/range_finder_v2.sv
// Framed min/max statistic engine: go/finish framing FSM, saturating sample count, result select.
// Define RANGE_FINDER_V2_SIGNED_EN for two's-complement samples.
module range_finder_v2
   import range_finder_v2_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             go,
   input  logic             finish,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] result,
   output logic [CNT_W-1:0] count,
   output logic             valid,
   output logic             busy,
   output logic             error
);

   state_t           state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   logic             load, upd;
   logic [WIDTH-1:0] min_nx, max_nx, range_nx, mid_nx;
   logic [WIDTH-1:0] stat_sel;

   range_minmax_unit #(.WIDTH(WIDTH)) u_minmax (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load),
      .upd_i   (upd),
      .data_i  (data_in),
      .min_o   (min_nx),
      .max_o   (max_nx),
      .range_o (range_nx),
      .mid_o   (mid_nx)
   );

   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      case (mode_q)
         MODE_MIN: stat_sel = min_nx;
         MODE_MAX: stat_sel = max_nx;
         MODE_MID: stat_sel = mid_nx;
         default:  stat_sel = range_nx;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      count_d  = count_q;
      valid_d  = valid_q;
      load     = 1'b0;
      upd      = 1'b0;
      case (state_q)
         IDLE, ERR: begin
            // ERR recovers through the same start path as IDLE.
            if (go && !finish) begin
               state_d = RUN;
               load    = 1'b1;
               cnt_d   = CNT_W'(1);
               mode_d  = mode_t'(mode);
               valid_d = 1'b0;
            end else if (go || finish) begin
               state_d = ERR;
               valid_d = 1'b0;
            end
         end
         RUN: begin
            if (go) begin
               state_d = ERR;
               valid_d = 1'b0;
            end else begin
               upd   = 1'b1;
               cnt_d = cnt_inc;
               if (finish) begin
                  state_d  = IDLE;
                  result_d = stat_sel;
                  count_d  = cnt_inc;
                  valid_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mode_q   <= MODE_RANGE;
         cnt_q    <= '0;
         result_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   assign result = result_q;
   assign count  = count_q;
   assign valid  = valid_q;
   assign busy   = (state_q == RUN);
   assign error  = (state_q == ERR);

endmodule
